// File: rtl/int_edge_cond_pkg.sv
// Shared interrupt register map, also used by the interrupt controller.
package int_edge_cond_pkg;

    typedef enum logic [1:0] {
        REG_EDGE = 2'd0,
        REG_POL  = 2'd1,
        REG_DEB  = 2'd2,
        REG_RAW  = 2'd3
    } int_reg_e;

endpackage

// File: rtl/int_sync_deb.sv
// One interrupt channel: 2-flop synchronizer, debounce filter, edge/level qualification.
// Raw-to-int_o latency 3+deb_i cycles; int_o is registered.
module int_sync_deb #(
    parameter int DBW = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           raw_i,
    input  logic           edge_mode_i,
    input  logic           pol_i,
    input  logic [DBW-1:0] deb_i,
    output logic           filt_o,
    output logic           int_o
);

    logic           s1_q, s1_d;
    logic           s2_q, s2_d;
    logic           filt_q, filt_d;
    logic           int_q, int_d;
    logic [DBW-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d   = raw_i;
        s2_d   = s1_q;
        filt_d = filt_q;
        cnt_d  = '0;
        // >= compare lets a lowered threshold take effect at once and keeps cnt from wrapping
        if (s2_q != filt_q) begin
            if (cnt_q >= deb_i) begin
                filt_d = s2_q;
            end else begin
                cnt_d = cnt_q + DBW'(1);
            end
        end
        if (edge_mode_i) begin
            int_d = (filt_d != filt_q) & (filt_d == pol_i);
        end else begin
            int_d = (filt_d == pol_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
            int_q  <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            int_q  <= int_d;
        end
    end

    assign filt_o = filt_q;
    assign int_o  = int_q;

endmodule

// File: rtl/int_edge_cond.sv
// Interrupt input conditioner with Wishbone config registers (EDGE, POL, DEB, RAW).
// Registered one-cycle ack; err/rty never asserted.
module int_edge_cond
    import int_edge_cond_pkg::*;
#(
    parameter int INT_NUM = 3,
    parameter int Dw      = 32,
    parameter int Aw      = 3,
    parameter int SELw    = 4,
    parameter int DBW     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [Dw-1:0]      sa_dat_i,
    input  logic [SELw-1:0]    sa_sel_i,
    input  logic [Aw-1:0]      sa_addr_i,
    input  logic               sa_stb_i,
    input  logic               sa_we_i,
    output logic [Dw-1:0]      sa_dat_o,
    output logic               sa_ack_o,
    output logic               sa_err_o,
    output logic               sa_rty_o,
    input  logic [INT_NUM-1:0] irq_raw_i,
    output logic [INT_NUM-1:0] int_o
);

    logic [INT_NUM-1:0] edge_q, edge_d;
    logic [INT_NUM-1:0] pol_q, pol_d;
    logic [DBW-1:0]     deb_q, deb_d;
    logic [Dw-1:0]      rd_q, rd_d;
    logic [Dw-1:0]      rd_val;
    logic               ack_q, ack_d;
    logic               wr_en, rd_en;
    logic [INT_NUM-1:0] filt;
    logic               unused_bits;

    always_comb begin
        wr_en  = sa_stb_i & sa_we_i;
        rd_en  = sa_stb_i & ~sa_we_i;
        edge_d = edge_q;
        pol_d  = pol_q;
        deb_d  = deb_q;
        if (wr_en) begin
            if (sa_addr_i == Aw'(REG_EDGE)) edge_d = sa_dat_i[INT_NUM-1:0];
            if (sa_addr_i == Aw'(REG_POL))  pol_d  = sa_dat_i[INT_NUM-1:0];
            if (sa_addr_i == Aw'(REG_DEB))  deb_d  = sa_dat_i[DBW-1:0];
        end
        rd_val = '0;
        if (sa_addr_i == Aw'(REG_EDGE)) rd_val[INT_NUM-1:0] = edge_q;
        if (sa_addr_i == Aw'(REG_POL))  rd_val[INT_NUM-1:0] = pol_q;
        if (sa_addr_i == Aw'(REG_DEB))  rd_val[DBW-1:0]     = deb_q;
        if (sa_addr_i == Aw'(REG_RAW))  rd_val[INT_NUM-1:0] = filt;
        rd_d  = rd_en ? rd_val : rd_q;
        ack_d = sa_stb_i & ~ack_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_q <= '0;
            pol_q  <= '1;
            deb_q  <= '0;
            rd_q   <= '0;
            ack_q  <= 1'b0;
        end else begin
            edge_q <= edge_d;
            pol_q  <= pol_d;
            deb_q  <= deb_d;
            rd_q   <= rd_d;
            ack_q  <= ack_d;
        end
    end

    for (genvar i = 0; i < INT_NUM; i++) begin : g_chan
        int_sync_deb #(
            .DBW(DBW)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .raw_i       (irq_raw_i[i]),
            .edge_mode_i (edge_q[i]),
            .pol_i       (pol_q[i]),
            .deb_i       (deb_q),
            .filt_o      (filt[i]),
            .int_o       (int_o[i])
        );
    end

    assign sa_dat_o    = rd_q;
    assign sa_ack_o    = ack_q;
    assign sa_err_o    = 1'b0;
    assign sa_rty_o    = 1'b0;
    assign unused_bits = ^{sa_sel_i, sa_dat_i};

endmodule

// File: tb/tb_int_edge_cond.sv
// Directed bench for int_edge_cond: vector table for level mode plus hand-written corner sequences.
module tb_int_edge_cond;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] sa_dat_i;
    logic [3:0]  sa_sel_i;
    logic [2:0]  sa_addr_i;
    logic        sa_stb_i;
    logic        sa_we_i;
    logic [31:0] sa_dat_o;
    logic        sa_ack_o;
    logic        sa_err_o;
    logic        sa_rty_o;
    logic [2:0]  irq_raw_i;
    logic [2:0]  int_o;

    int checks = 0;
    int errors = 0;
    int hi_cnt [3] = '{0, 0, 0};

    typedef struct {
        logic [2:0] raw;
        logic [2:0] exp;
    } vec_t;
    vec_t tbl [14];

    always #5 clk = ~clk;

    int_edge_cond #(
        .INT_NUM(3), .Dw(32), .Aw(3), .SELw(4), .DBW(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sa_dat_i  (sa_dat_i),
        .sa_sel_i  (sa_sel_i),
        .sa_addr_i (sa_addr_i),
        .sa_stb_i  (sa_stb_i),
        .sa_we_i   (sa_we_i),
        .sa_dat_o  (sa_dat_o),
        .sa_ack_o  (sa_ack_o),
        .sa_err_o  (sa_err_o),
        .sa_rty_o  (sa_rty_o),
        .irq_raw_i (irq_raw_i),
        .int_o     (int_o)
    );

    // Count high cycles per channel, sampled away from the active edge
    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (int_o[c]) hi_cnt[c]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
        sa_stb_i  = 1'b1;
        sa_we_i   = 1'b1;
        sa_addr_i = a;
        sa_dat_i  = d;
        tick();
        sa_stb_i  = 1'b0;
        sa_we_i   = 1'b0;
        tick();
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
        sa_stb_i  = 1'b1;
        sa_we_i   = 1'b0;
        sa_addr_i = a;
        tick();
        check("rd_ack", {31'd0, sa_ack_o}, 32'd1);
        d = sa_dat_o;
        sa_stb_i  = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        int          npulse;
        int          pos;
        int          snap;

        tbl[0]  = '{3'b001, 3'b000};
        tbl[1]  = '{3'b001, 3'b000};
        tbl[2]  = '{3'b001, 3'b001};
        tbl[3]  = '{3'b011, 3'b001};
        tbl[4]  = '{3'b011, 3'b001};
        tbl[5]  = '{3'b110, 3'b011};
        tbl[6]  = '{3'b000, 3'b011};
        tbl[7]  = '{3'b000, 3'b110};
        tbl[8]  = '{3'b000, 3'b000};
        tbl[9]  = '{3'b101, 3'b000};
        tbl[10] = '{3'b101, 3'b000};
        tbl[11] = '{3'b000, 3'b101};
        tbl[12] = '{3'b000, 3'b101};
        tbl[13] = '{3'b000, 3'b000};

        reset     = 1'b1;
        sa_dat_i  = '0;
        sa_sel_i  = 4'hF;
        sa_addr_i = '0;
        sa_stb_i  = 1'b0;
        sa_we_i   = 1'b0;
        irq_raw_i = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset defaults
        check("rst_int_o", {29'd0, int_o}, 32'd0);
        check("rst_ack", {31'd0, sa_ack_o}, 32'd0);
        check("rst_dat_o", sa_dat_o, 32'd0);
        check("rst_err_rty", {30'd0, sa_err_o, sa_rty_o}, 32'd0);
        wb_read(3'd3, rd); check("rst_raw", rd, 32'd0);
        wb_read(3'd1, rd); check("rst_pol", rd, 32'd7);
        wb_read(3'd0, rd); check("rst_edge", rd, 32'd0);
        wb_read(3'd2, rd); check("rst_deb", rd, 32'd0);

        // Level mode, DEB=0: int_o follows raw three cycles later
        for (int k = 0; k < 14; k++) begin
            irq_raw_i = tbl[k].raw;
            tick();
            check($sformatf("lvl_vec%0d", k), {29'd0, int_o}, {29'd0, tbl[k].exp});
        end

        // Rising edge on channel 1 with DEB=4: single pulse at N+7
        wb_write(3'd0, 32'h2);
        wb_write(3'd2, 32'h4);
        irq_raw_i[1] = 1'b1;
        npulse = 0;
        pos    = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (int_o[1]) begin
                npulse++;
                pos = t;
            end
        end
        check("rise_npulse", npulse, 1);
        check("rise_pos", pos, 7);
        wb_read(3'd3, rd); check("rise_raw", rd, 32'h2);
        snap = hi_cnt[1];
        irq_raw_i[1] = 1'b0;
        repeat (10) tick();
        irq_raw_i[1] = 1'b1;
        repeat (3) tick();
        irq_raw_i[1] = 1'b0;
        repeat (10) tick();
        check("fall_glitch_nopulse", hi_cnt[1] - snap, 0);
        wb_read(3'd3, rd); check("glitch_raw", rd, 32'h0);

        // Falling edge on channel 2, DEB=0
        wb_write(3'd2, 32'h0);
        snap = hi_cnt[2];
        wb_write(3'd0, 32'h4);
        wb_write(3'd1, 32'h3);
        irq_raw_i[2] = 1'b1;
        repeat (6) tick();
        check("neg_rise_nopulse", hi_cnt[2] - snap, 0);
        irq_raw_i[2] = 1'b0;
        npulse = 0;
        pos    = 0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (int_o[2]) begin
                npulse++;
                pos = t;
            end
        end
        check("neg_npulse", npulse, 1);
        check("neg_pos", pos, 3);
        snap = hi_cnt[2];
        wb_write(3'd1, 32'h7);
        wb_write(3'd1, 32'h3);
        repeat (4) tick();
        check("pol_rewrite_nopulse", hi_cnt[2] - snap, 0);

        // Level output picks up a new POL one cycle after the write
        wb_write(3'd0, 32'h0);
        sa_stb_i = 1'b1; sa_we_i = 1'b1; sa_addr_i = 3'd1; sa_dat_i = 32'h6;
        tick();
        sa_stb_i = 1'b0; sa_we_i = 1'b0;
        check("pol_lvl_wr_edge", {31'd0, int_o[0]}, 32'd0);
        tick();
        check("pol_lvl_next", {31'd0, int_o[0]}, 32'd1);
        wb_write(3'd1, 32'h7);
        tick();
        check("pol_lvl_restore", {29'd0, int_o}, 32'd0);

        // DEB lowered from 20 to 2 while the counter sits at 10
        wb_write(3'd2, 32'd20);
        irq_raw_i[0] = 1'b1;
        repeat (12) tick();
        check("deb20_hold", {31'd0, int_o[0]}, 32'd0);
        sa_stb_i = 1'b1; sa_we_i = 1'b1; sa_addr_i = 3'd2; sa_dat_i = 32'd2;
        tick();
        sa_stb_i = 1'b0; sa_we_i = 1'b0;
        check("deb_lower_wr", {31'd0, int_o[0]}, 32'd0);
        tick();
        check("deb_lower_next", {31'd0, int_o[0]}, 32'd1);

        // Wishbone: continuous read of DEB, RAW write ignored, unmapped reads 0
        check("ack_idle", {31'd0, sa_ack_o}, 32'd0);
        sa_stb_i = 1'b1; sa_we_i = 1'b0; sa_addr_i = 3'd2;
        tick();
        check("ack_seq0", {31'd0, sa_ack_o}, 32'd1);
        check("deb_rd", sa_dat_o, 32'd2);
        tick();
        check("ack_seq1", {31'd0, sa_ack_o}, 32'd0);
        tick();
        check("ack_seq2", {31'd0, sa_ack_o}, 32'd1);
        check("err_rty", {30'd0, sa_err_o, sa_rty_o}, 32'd0);
        sa_stb_i = 1'b0;
        tick();
        wb_write(3'd3, 32'hFF);
        wb_read(3'd3, rd); check("raw_wr_ignored", rd, 32'h1);
        wb_write(3'd6, 32'h0);
        wb_read(3'd5, rd); check("unmapped_rd", rd, 32'h0);
        wb_read(3'd1, rd); check("unmapped_wr_pol", rd, 32'h7);

        // Reset during a debounce aborts it without a later pulse
        wb_write(3'd2, 32'd20);
        irq_raw_i = '0;
        repeat (5) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        snap = hi_cnt[0] + hi_cnt[1] + hi_cnt[2];
        tick();
        check("post_rst_int", {29'd0, int_o}, 32'd0);
        repeat (5) tick();
        check("post_rst_quiet", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] - snap, 0);
        wb_read(3'd2, rd); check("post_rst_deb", rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_edge_cond.md
INT_EDGE_COND -- requirements
Module: int_edge_cond

Interface
REQ-001 SHALL have parameter INT_NUM, default 3, number of interrupt channels (1..32).
REQ-002 SHALL have parameter Dw, default 32, Wishbone data width.
REQ-003 SHALL have parameter Aw, default 3, Wishbone address width.
REQ-004 SHALL have parameter SELw, default 4, Wishbone select width.
REQ-005 SHALL have parameter DBW, default 8, debounce counter width (1..Dw).
REQ-006 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have ports sa_dat_i in Dw, sa_sel_i in SELw (ignored), sa_addr_i in Aw, sa_stb_i in 1, sa_we_i in 1: Wishbone slave request.
REQ-009 SHALL have ports sa_dat_o out Dw, sa_ack_o out 1, sa_err_o out 1 (tied 0), sa_rty_o out 1 (tied 0): Wishbone slave response.
REQ-010 SHALL have port irq_raw_i  input  INT_NUM  asynchronous raw interrupt lines from peripherals/pins.
REQ-011 SHALL have port int_o  output  INT_NUM  conditioned interrupts, registered, driving the interrupt controller's int_i.

Function
REQ-012 Register map (word index on sa_addr_i): 0 EDGE (1=edge, 0=level per channel), 1 POL (1=rising/active-high, 0=falling/active-low), 2 DEB (DBW-bit debounce count, shared), 3 RAW (read-only filtered level per channel).
REQ-013 Write: when sa_stb_i & sa_we_i, addressed writable register loads sa_dat_i low bits at next edge; writes to RAW or unmapped addresses ignored.
REQ-014 Read: when sa_stb_i & ~sa_we_i, read register loads addressed value zero-extended to Dw at next edge; unmapped address loads 0; sa_dat_o is the read register.
REQ-015 sa_ack_o SHALL be registered: sa_ack_o <= sa_stb_i & ~sa_ack_o (one-cycle ack, alternating under continuous strobe).
REQ-016 Each channel SHALL pass irq_raw_i through a 2-flop synchronizer (s1, s2).
REQ-017 Debounce per channel: counter clears when s2 == filt; increments while s2 != filt; when s2 != filt and cnt >= DEB, filt <= s2 and cnt <= 0.
REQ-018 DEB=0 SHALL make filt follow s2 with one cycle delay; total raw-to-int_o latency is 3+DEB cycles.
REQ-019 Level mode: int_o[i] <= (filt_next[i] == POL[i]).
REQ-020 Edge mode: int_o[i] <= (filt_next[i] != filt[i]) & (filt_next[i] == POL[i]); exactly one-cycle pulse per qualifying transition.
REQ-021 Changing POL/EDGE SHALL NOT itself produce an edge pulse; level outputs reflect new POL from the cycle after the write.
REQ-022 Lowering DEB below a running counter SHALL cause transfer on the next cycle (>= compare); counter never wraps.
REQ-023 Glitches shorter than DEB+1 synchronized cycles SHALL produce no filt change and no int_o activity.

Reset
REQ-024 On reset: EDGE=0, POL=all ones, DEB=0, s1/s2/filt/cnt=0, read register=0, int_o=0, sa_ack_o=0.
REQ-025 Reset asserted mid-debounce or mid-pulse SHALL abort it; no pulse is emitted on the cycle after reset deasserts.

Structure
REQ-026 Register address constants (EDGE, POL, DEB, RAW) SHALL live in a shared interrupt package used with the interrupt controller.
REQ-027 Per-channel synchronizer + debouncer + edge/level logic SHALL be sub-module int_sync_deb, instantiated INT_NUM times via generate; bus decode stays in top.

Verification
REQ-028 Reset defaults: after reset, irq_raw_i=0 -> int_o=0; read addr 3 -> 0; read addr 1 -> all ones (INT_NUM bits).
REQ-029 Level, DEB=0: irq_raw_i[0] 0->1 at edge N -> int_o[0]=1 from edge N+3, stays high until input falls, drops 3 cycles after fall.
REQ-030 Edge rising, DEB=4: write EDGE=1, DEB=4; hold irq_raw_i[1]=1 -> single 1-cycle int_o[1] pulse at N+7; 3-cycle glitch -> no pulse.
REQ-031 Falling edge: EDGE=1, POL=0 on channel 2; drive 1 then 0 -> pulse only on fall; rising produces none; rewriting POL produces none.
REQ-032 DEB lowered from 20 to 2 while cnt=10 -> filt transfers next cycle; int_o follows one edge later.
REQ-033 Wishbone: continuous stb read of addr 2 -> ack toggles 1,0,1; sa_dat_o=DEB; write to addr 3 leaves RAW unchanged; err/rty always 0.
